cipher_bus_if: RTL and testbench

- Slave-side endpoint for the key bus and the cipher bus, with an iterative AES-128 encryption engine behind them.
- Accepts a 128-bit key, then 128-bit plaintext blocks, and returns 128-bit ciphertext blocks.
- Sits between the testbench master (key/cipher masters) and the rest of the design.
- All buses use valid/ready handshakes.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes_round.sv | 34 +++
 rtl/cipher_bus_if.sv | 118 +++++++++++
 tb/tb_cipher_bus_if.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 types, constants and helper functions shared by the round datapath and the bus endpoint.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  // Indexed directly by the 4-bit round counter; entries 0 and 11..15 are never used.
  localparam logic [0:15][7:0] RCON = 128'h00_01_02_04_08_10_20_40_80_1b_36_00_00_00_00_00;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX[b];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, byte 0 in the top bits.
  function automatic word_t mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic block_t key_expand_step(input block_t k, input byte_t rc);
    word_t w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    // SubWord(RotWord(w3)) xor Rcon
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES-128 round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey with the
// round key expanded on the fly from the previous one.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_rkey
);

  logic [15:0][7:0] sb;
  logic [15:0][7:0] sr;
  logic [127:0]     mixed;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state[127-8*i -: 8]);
  end

  // Byte (row r, column c) lives at index 4*c + r; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mixed[127-32*c -: 32] = last ? {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]}
                                        : mix_column({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
  end

  assign next_rkey  = key_expand_step(rkey, rcon);
  assign next_state = mixed ^ next_rkey;

endmodule

// File: rtl/cipher_bus_if.sv
// Key/cipher bus endpoint with an iterative AES-128 encryptor (one round per cycle).
// Define CIPHER_BUS_STATS_EN to add the blk_count completed-block counter output.
module cipher_bus_if
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         resetH,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_data,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] pt_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data,
  output logic         busy
`ifdef CIPHER_BUS_STATS_EN
  ,
  output logic [CNT_W-1:0] blk_count
`endif
);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] key_q;
  logic         key_loaded_q;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] rnd_state, rnd_rkey;
  logic         key_xfer, pt_xfer;

  assign key_ready = (fsm_q == IDLE);
  // A key offered in the same cycle wins over plaintext.
  assign pt_ready  = (fsm_q == IDLE) && key_loaded_q && !key_valid;
  assign key_xfer  = key_valid && key_ready;
  assign pt_xfer   = pt_valid && pt_ready;
  assign ct_valid  = (fsm_q == DONE);
  assign ct_data   = ct_valid ? state_q : '0;
  assign busy      = (fsm_q != IDLE);

  aes_round u_round (
    .state      (state_q),
    .rkey       (rkey_q),
    .rcon       (RCON[round_q]),
    .last       (round_q == 4'd10),
    .next_state (rnd_state),
    .next_rkey  (rnd_rkey)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (pt_xfer) begin
          state_d = pt_data ^ key_q;
          rkey_d  = key_q;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rnd_state;
        rkey_d  = rnd_rkey;
        if (round_q == 4'd10) begin
          round_d = 4'd0;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (ct_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetH) begin
    if (!resetH) begin
      fsm_q        <= IDLE;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      state_q      <= '0;
      rkey_q       <= '0;
      round_q      <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
      if (key_xfer) begin
        key_q        <= key_data;
        key_loaded_q <= 1'b1;
      end
    end
  end

`ifdef CIPHER_BUS_STATS_EN
  logic [CNT_W-1:0] blk_count_q;

  always_ff @(posedge clk or negedge resetH) begin
    if (!resetH) begin
      blk_count_q <= '0;
    end else if (ct_valid && ct_ready) begin
      blk_count_q <= blk_count_q + 1'b1;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_cipher_bus_if.sv
// Scoreboard bench for cipher_bus_if: stimulus pushes expected ciphertext, a monitor checks outputs.
module tb_cipher_bus_if;

  localparam int unsigned CNT_W = 16;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         resetH;
  logic         key_valid, key_ready;
  logic [127:0] key_data;
  logic         pt_valid, pt_ready;
  logic [127:0] pt_data;
  logic         ct_valid, ct_ready;
  logic [127:0] ct_data;
  logic         busy;
`ifdef CIPHER_BUS_STATS_EN
  logic [CNT_W-1:0] blk_count;
`endif

  cipher_bus_if #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetH    (resetH),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .pt_data   (pt_data),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .ct_data   (ct_data),
    .busy      (busy)
`ifdef CIPHER_BUS_STATS_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ct   = 0;
  logic mon_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge so stimulus changes there have settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (resetH && ct_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ct: got %h expected no output", ct_data);
        end else begin
          check("ct_data", ct_data, sb[0].data);
          if (!mon_prev) check("ct_latency", 128'(cyc), 128'(sb[0].cyc));
          if (ct_ready) begin
            void'(sb.pop_front());
            n_ct++;
          end
        end
      end
      mon_prev = resetH && ct_valid;
    end
  end

  task automatic load_key(input logic [127:0] k);
    int n = 0;
    @(negedge clk);
    key_valid = 1'b1;
    key_data  = k;
    #1;
    while (!key_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL key_accept_timeout: key_ready=0 expected 1");
    end
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_pt(input logic [127:0] pt, input logic [127:0] exp, output int acc);
    int n = 0;
    @(negedge clk);
    pt_valid = 1'b1;
    pt_data  = pt;
    #1;
    while (!pt_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = cyc + 1;
    if (!pt_ready) begin
      checks++;
      errors++;
      $display("FAIL pt_accept_timeout: pt_ready=0 expected 1");
    end else begin
      sb.push_back('{data: exp, cyc: cyc + 11});
    end
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d blocks outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, n;
    resetH    = 1'b0;
    key_valid = 1'b0;
    key_data  = '0;
    pt_valid  = 1'b0;
    pt_data   = '0;
    ct_ready  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_key_ready", key_ready, 1);
    check("rst_pt_ready", pt_ready, 0);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_ct_data", ct_data, 0);
    check("rst_busy", busy, 0);
`ifdef CIPHER_BUS_STATS_EN
    check("rst_blk_count", blk_count, 0);
`endif
    @(negedge clk);
    resetH = 1'b1;

    // Plaintext offered before any key: must not be accepted
    pt_valid = 1'b1;
    pt_data  = PT1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("pt_ready_nokey", pt_ready, 0);
    end
    pt_valid = 1'b0;
    load_key(K1);
    send_pt(PT1, CT1, acc_a);
    drain();

    // Vector 2, then a back-to-back block to check the 12-cycle issue interval
    load_key(K2);
    send_pt(PT2, CT2, acc_a);
    send_pt(PT2, CT2, acc_b);
    check("b2b_interval", 128'(acc_b - acc_a), 128'd12);
    drain();

    // Backpressure: DONE held while ct_ready is low
    ct_ready = 1'b0;
    load_key(K1);
    send_pt(PT1, CT1, acc_a);
    n = 0;
    #1;
    while (!ct_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_ct_valid_seen", ct_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_ct_valid", ct_valid, 1);
      check("bp_key_ready", key_ready, 0);
      check("bp_pt_ready", pt_ready, 0);
    end
    @(negedge clk);
    ct_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_idle", key_ready, 1);
    check("bp_release_busy", busy, 0);
    check("bp_release_ct_valid", ct_valid, 0);
    drain();

    // Reset during round 5 aborts the block and forgets the key
    load_key(K1);
    send_pt(PT1, CT1, acc_a);
    repeat (4) @(negedge clk);
    resetH = 1'b0;
    sb.delete();
    #1;
    check("abort_ct_valid", ct_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_key_ready", key_ready, 1);
    repeat (2) @(negedge clk);
    resetH   = 1'b1;
    pt_valid = 1'b1;
    pt_data  = PT2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("abort_key_cleared", pt_ready, 0);
    end
    pt_valid = 1'b0;
    load_key(K2);
    send_pt(PT2, CT2, acc_a);
    drain();

    // Three blocks with key changes between them, counted from a fresh reset
    @(negedge clk);
    resetH = 1'b0;
    n_ct   = 0;
    @(negedge clk);
    resetH = 1'b1;
    load_key(K1);
    send_pt(PT1, CT1, acc_a);
    load_key(K2);
    send_pt(PT2, CT2, acc_a);
    load_key(K1);
    send_pt(PT1, CT1, acc_a);
    drain();
    check("blocks_transferred", 128'(n_ct), 128'd3);
`ifdef CIPHER_BUS_STATS_EN
    @(negedge clk);
    #1;
    check("blk_count", blk_count, 3);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
